// File: rtl/bch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bch_pkg                                                              |
// | GF(2^m) helpers and derived-geometry functions shared by the BCH     |
// | encoder and syndrome checker.                                        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bch_pkg;

  localparam int C_MAX_M = 16;

  typedef logic [C_MAX_M-1:0] gf_t;
  typedef logic [C_MAX_M:0]   gf_poly_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } bch_state_t;

  function automatic gf_t F_mult(input gf_t a, input gf_t b, input int m, input gf_poly_t poly);
    gf_poly_t p;
    p = '0;
    for (int i = C_MAX_M - 1; i >= 0; i--) begin
      if (i < m) begin
        p = p << 1;
        if (p[m]) p = p ^ poly;
        if (b[i]) p = p ^ {1'b0, a};
      end
    end
    return p[C_MAX_M-1:0];
  endfunction

  // alpha^e by square-and-multiply so large exponents stay cheap to elaborate
  function automatic gf_t F_gen(input int e, input int m, input gf_poly_t poly);
    int  n;
    int  ex;
    gf_t r;
    gf_t b;
    n    = (1 << m) - 1;
    ex   = e % n;
    r    = '0;
    r[0] = 1'b1;
    b    = '0;
    b[1] = 1'b1;
    for (int i = 0; i < 31; i++) begin
      if (ex[i]) r = F_mult(r, b, m, poly);
      b = F_mult(b, b, m, poly);
    end
    return r;
  endfunction

  // Generator degree: sum of the sizes of the distinct cyclotomic cosets
  // containing the odd roots 1, 3, ..., 2t-1.
  function automatic int F_gen_width(input int t, input int m);
    int n;
    int w;
    int x;
    int sz;
    bit is_min;
    bit done;
    n = (1 << m) - 1;
    w = 0;
    for (int j = 1; j < 2 * t; j += 2) begin
      x      = j;
      sz     = 0;
      is_min = 1'b1;
      done   = 1'b0;
      for (int k = 1; k <= m; k++) begin
        x = (x * 2) % n;
        if (x < j) is_min = 1'b0;
        if (!done && x == j) begin
          sz   = k;
          done = 1'b1;
        end
      end
      if (is_min) w = w + sz;
    end
    return w;
  endfunction

  function automatic int GETASIZE(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int F_ecc_beats(input int gen_width, input int dwidth);
    return (gen_width - 1) / dwidth + 1;
  endfunction

  function automatic int F_pad(input int gen_width, input int dwidth);
    return F_ecc_beats(gen_width, dwidth) * dwidth - gen_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bch_synd_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bch_synd_acc                                                         |
// | One syndrome accumulator S_j, updated by constant GF XOR matrices.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bch_synd_acc
  import bch_pkg::*;
#(
  parameter int                        C_DWIDTH         = 128,
  parameter int                        C_PRIMPOLY_ORDER = 14,
  parameter logic [C_PRIMPOLY_ORDER:0] C_PRIM_POLY      = 15'h4443,
  parameter int                        C_PAD            = 0,
  parameter int                        C_J              = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [C_DWIDTH-1:0]         data_i,
  input  logic                        upd_i,
  input  logic                        first_i,
  input  logic                        last_i,
  output logic [C_PRIMPOLY_ORDER-1:0] synd_nxt_o
);

  localparam int       C_M    = C_PRIMPOLY_ORDER;
  localparam gf_poly_t C_POLY = gf_poly_t'(C_PRIM_POLY);

  typedef logic [C_DWIDTH-1:0][C_M-1:0] dcols_t;
  typedef logic [C_M-1:0][C_M-1:0]      scols_t;

  // Column k holds alpha^(j*(k-skip)); bits below skip are pad and contribute nothing.
  function automatic dcols_t f_data_cols(input int skip);
    dcols_t c;
    gf_t    p;
    gf_t    a;
    c    = '0;
    p    = '0;
    p[0] = 1'b1;
    a    = F_gen(C_J, C_M, C_POLY);
    for (int k = 0; k < C_DWIDTH; k++) begin
      if (k >= skip) begin
        c[k] = p[C_M-1:0];
        p    = F_mult(p, a, C_M, C_POLY);
      end
    end
    return c;
  endfunction

  function automatic scols_t f_state_cols(input int shift);
    scols_t c;
    gf_t    a;
    gf_t    basis;
    gf_t    prod;
    a = F_gen(C_J * shift, C_M, C_POLY);
    for (int b = 0; b < C_M; b++) begin
      basis    = '0;
      basis[b] = 1'b1;
      prod     = F_mult(basis, a, C_M, C_POLY);
      c[b]     = prod[C_M-1:0];
    end
    return c;
  endfunction

  localparam dcols_t C_DCOLS_MID  = f_data_cols(0);
  localparam dcols_t C_DCOLS_LAST = f_data_cols(C_PAD);
  localparam scols_t C_SCOLS_MID  = f_state_cols(C_DWIDTH);
  localparam scols_t C_SCOLS_LAST = f_state_cols(C_DWIDTH - C_PAD);

  logic [C_M-1:0] synd_q;
  logic [C_M-1:0] synd_d;
  logic [C_M-1:0] w_prior;
  logic [C_M-1:0] w_mid;
  logic [C_M-1:0] w_last;

  always_comb begin
    w_prior = first_i ? '0 : synd_q;
    w_mid   = '0;
    w_last  = '0;
    for (int b = 0; b < C_M; b++) begin
      if (w_prior[b]) begin
        w_mid  = w_mid ^ C_SCOLS_MID[b];
        w_last = w_last ^ C_SCOLS_LAST[b];
      end
    end
    for (int k = 0; k < C_DWIDTH; k++) begin
      if (data_i[k]) begin
        w_mid  = w_mid ^ C_DCOLS_MID[k];
        w_last = w_last ^ C_DCOLS_LAST[k];
      end
    end
    synd_d = last_i ? w_last : w_mid;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      synd_q <= '0;
    end else if (upd_i) begin
      synd_q <= synd_d;
    end
  end

  assign synd_nxt_o = synd_d;

endmodule
`default_nettype wire

// File: rtl/bch_syndrome_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bch_syndrome_check                                                   |
// | Computes odd BCH syndromes per frame and strips parity beats.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bch_syndrome_check
  import bch_pkg::*;
#(
  parameter int                        C_DWIDTH         = 128,
  parameter int                        C_COEF_NUM       = 43,
  parameter int                        C_PRIMPOLY_ORDER = 14,
  parameter logic [C_PRIMPOLY_ORDER:0] C_PRIM_POLY      = 15'h4443
) (
  input  logic                                   I_clk,
  input  logic                                   I_rst,
  input  logic [C_DWIDTH-1:0]                    I_data,
  input  logic                                   I_data_v,
  input  logic                                   I_data_sof,
  input  logic                                   I_data_eof,
  output logic [C_DWIDTH-1:0]                    O_data,
  output logic                                   O_data_v,
  output logic                                   O_data_sof,
  output logic                                   O_data_eof,
  output logic [C_COEF_NUM*C_PRIMPOLY_ORDER-1:0] O_synd,
  output logic                                   O_synd_v,
  output logic                                   O_err,
  output logic                                   O_len_err
);

  localparam int C_M         = C_PRIMPOLY_ORDER;
  localparam int C_SW        = C_COEF_NUM * C_M;
  localparam int C_GEN_WIDTH = F_gen_width(C_COEF_NUM, C_M);
  localparam int C_ECC_BEATS = F_ecc_beats(C_GEN_WIDTH, C_DWIDTH);
  localparam int C_PAD       = F_pad(C_GEN_WIDTH, C_DWIDTH);
  localparam int C_OCC_W     = GETASIZE(C_ECC_BEATS);
  localparam logic [C_OCC_W-1:0] C_OCC_FULL = C_OCC_W'(C_ECC_BEATS);

  bch_state_t                              state_q, state_d;
  logic [C_ECC_BEATS-1:0][C_DWIDTH-1:0]    line_q, line_d;
  logic [C_OCC_W-1:0]                      occ_q, occ_d;
  logic                                    pend_q, pend_d;
  logic [C_DWIDTH-1:0]                     data_q, data_d;
  logic                                    data_v_q, data_v_d;
  logic                                    dsof_q, dsof_d;
  logic                                    deof_q, deof_d;
  logic [C_SW-1:0]                         synd_q, synd_d;
  logic                                    synd_v_q, synd_v_d;
  logic                                    err_q, err_d;
  logic                                    len_err_q, len_err_d;

  logic            w_take;
  logic            w_emit;
  logic [C_SW-1:0] w_synd_nxt;

  // Beats outside a frame are ignored unless they open one.
  assign w_take = I_data_v && (I_data_sof || (state_q == ST_FRAME));
  assign w_emit = w_take && !I_data_sof && (occ_q == C_OCC_FULL);

  for (genvar gi = 0; gi < C_COEF_NUM; gi++) begin : g_acc
    bch_synd_acc #(
      .C_DWIDTH         (C_DWIDTH),
      .C_PRIMPOLY_ORDER (C_PRIMPOLY_ORDER),
      .C_PRIM_POLY      (C_PRIM_POLY),
      .C_PAD            (C_PAD),
      .C_J              (2 * gi + 1)
    ) u_acc (
      .clk_i      (I_clk),
      .rst_i      (I_rst),
      .data_i     (I_data),
      .upd_i      (w_take),
      .first_i    (I_data_sof),
      .last_i     (I_data_eof),
      .synd_nxt_o (w_synd_nxt[gi*C_M +: C_M])
    );
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    occ_d     = occ_q;
    pend_d    = pend_q;
    data_d    = data_q;
    data_v_d  = 1'b0;
    dsof_d    = 1'b0;
    deof_d    = 1'b0;
    synd_d    = synd_q;
    synd_v_d  = 1'b0;
    err_d     = err_q;
    len_err_d = len_err_q;
    if (w_take) begin
      line_d[0] = I_data;
      for (int i = 1; i < C_ECC_BEATS; i++) begin
        line_d[i] = line_q[i-1];
      end
      if (I_data_sof) begin
        state_d = ST_FRAME;
        occ_d   = C_OCC_W'(1);
        pend_d  = 1'b1;
      end else if (occ_q != C_OCC_FULL) begin
        occ_d = occ_q + C_OCC_W'(1);
      end
      if (w_emit) begin
        data_d   = line_q[C_ECC_BEATS-1];
        data_v_d = 1'b1;
        dsof_d   = pend_q;
        pend_d   = 1'b0;
      end
      // Whatever is still in the line at eof is parity; dropping occupancy discards it.
      if (I_data_eof) begin
        state_d   = ST_IDLE;
        occ_d     = '0;
        deof_d    = w_emit;
        synd_v_d  = 1'b1;
        synd_d    = w_synd_nxt;
        err_d     = |w_synd_nxt;
        len_err_d = !w_emit;
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= ST_IDLE;
      line_q    <= '0;
      occ_q     <= '0;
      pend_q    <= 1'b0;
      data_q    <= '0;
      data_v_q  <= 1'b0;
      dsof_q    <= 1'b0;
      deof_q    <= 1'b0;
      synd_q    <= '0;
      synd_v_q  <= 1'b0;
      err_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      occ_q     <= occ_d;
      pend_q    <= pend_d;
      data_q    <= data_d;
      data_v_q  <= data_v_d;
      dsof_q    <= dsof_d;
      deof_q    <= deof_d;
      synd_q    <= synd_d;
      synd_v_q  <= synd_v_d;
      err_q     <= err_d;
      len_err_q <= len_err_d;
    end
  end

  assign O_data     = data_q;
  assign O_data_v   = data_v_q;
  assign O_data_sof = dsof_q;
  assign O_data_eof = deof_q;
  assign O_synd     = synd_q;
  assign O_synd_v   = synd_v_q;
  assign O_err      = err_q;
  assign O_len_err  = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_syndrome_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bch_syndrome_check                                                |
// | Directed and random frames against a polynomial-evaluation model.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bch_syndrome_check;

  localparam int DW = 8;
  localparam int E  = 1;

  logic        clk = 1'b0;
  logic        I_rst;
  logic [7:0]  I_data;
  logic        I_data_v, I_data_sof, I_data_eof;
  logic [7:0]  O_data;
  logic        O_data_v, O_data_sof, O_data_eof;
  logic [7:0]  O_synd;
  logic        O_synd_v, O_err, O_len_err;

  bch_syndrome_check #(
    .C_DWIDTH         (DW),
    .C_COEF_NUM       (2),
    .C_PRIMPOLY_ORDER (4),
    .C_PRIM_POLY      (5'h13)
  ) dut (
    .I_clk      (clk),
    .I_rst      (I_rst),
    .I_data     (I_data),
    .I_data_v   (I_data_v),
    .I_data_sof (I_data_sof),
    .I_data_eof (I_data_eof),
    .O_data     (O_data),
    .O_data_v   (O_data_v),
    .O_data_sof (O_data_sof),
    .O_data_eof (O_data_eof),
    .O_synd     (O_synd),
    .O_synd_v   (O_synd_v),
    .O_err      (O_err),
    .O_len_err  (O_len_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] alog [0:14];
  logic [7:0] fr [$];
  bit         in_frame = 1'b0;
  logic [7:0] exp_data = '0;
  logic [7:0] exp_synd = '0;
  logic       exp_err = 1'b0;
  logic       exp_len = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // S_j = r(alpha^j), first bit in time has the highest exponent.
  function automatic logic [7:0] frame_synd();
    int         len;
    int         ex;
    logic [3:0] s1;
    logic [3:0] s3;
    len = fr.size() * 8;
    s1  = '0;
    s3  = '0;
    for (int t = 0; t < fr.size(); t++) begin
      for (int b = 7; b >= 0; b--) begin
        if (fr[t][b]) begin
          ex = len - 1 - (8 * t + 7 - b);
          s1 = s1 ^ alog[ex % 15];
          s3 = s3 ^ alog[(3 * ex) % 15];
        end
      end
    end
    return {s3, s1};
  endfunction

  function automatic logic [7:0] parity(input logic [63:0] d);
    logic [63:0] r;
    r = d << 8;
    for (int i = 63; i >= 8; i--) begin
      if (r[i]) r = r ^ (64'h1D1 << (i - 8));
    end
    return r[7:0];
  endfunction

  task automatic step(input logic v, input logic s, input logic e, input logic [7:0] d);
    logic acc, emit, esof, eeof, sv;
    int   k;
    I_data_v   = v;
    I_data_sof = s;
    I_data_eof = e;
    I_data     = d;
    acc  = v && (s || in_frame);
    emit = 1'b0;
    esof = 1'b0;
    eeof = 1'b0;
    sv   = 1'b0;
    if (acc) begin
      if (s) begin
        fr.delete();
        in_frame = 1'b1;
      end
      fr.push_back(d);
      k = fr.size() - 1;
      if (k >= E) begin
        emit     = 1'b1;
        exp_data = fr[k-E];
        esof     = (k == E);
        eeof     = e;
      end
      if (e) begin
        sv       = 1'b1;
        exp_synd = frame_synd();
        exp_err  = (exp_synd != 8'h00);
        exp_len  = (fr.size() <= E);
        in_frame = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("data_v", O_data_v, emit);
    if (emit) chk("data", O_data, exp_data);
    chk("data_sof", O_data_sof, esof);
    chk("data_eof", O_data_eof, eeof);
    chk("synd_v", O_synd_v, sv);
    chk("synd", O_synd, exp_synd);
    if (sv) begin
      chk("err", O_err, exp_err);
      chk("len_err", O_len_err, exp_len);
    end
  endtask

  initial begin
    logic [4:0]  a;
    logic [63:0] dat;
    logic [7:0]  bt [$];
    logic [7:0]  tmp;
    int          nd, mode, pos, nb;

    a = 5'h01;
    for (int i = 0; i < 15; i++) begin
      alog[i] = a[3:0];
      a = a << 1;
      if (a[4]) a = a ^ 5'h13;
    end

    I_rst = 1'b1; I_data = '0; I_data_v = 1'b0; I_data_sof = 1'b0; I_data_eof = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_data_v", O_data_v, 1'b0);
    chk("rst_synd_v", O_synd_v, 1'b0);
    chk("rst_synd", O_synd, 8'h00);
    chk("rst_data", O_data, 8'h00);
    I_rst = 1'b0;

    // Clean codeword
    step(1, 1, 0, 8'h01);
    step(1, 0, 1, 8'hD1);
    chk("s1_data", O_data, 8'h01);
    chk("s1_sof", O_data_sof, 1'b1);
    chk("s1_synd", O_synd, 8'h00);
    chk("s1_err", O_err, 1'b0);

    // Single errors in parity bits 0 and 1, back-to-back frames
    step(1, 1, 0, 8'h01);
    step(1, 0, 1, 8'hD0);
    chk("s2_synd", O_synd, 8'h11);
    chk("s2_err", O_err, 1'b1);
    chk("s2_data", O_data, 8'h01);
    step(1, 1, 0, 8'h01);
    step(1, 0, 1, 8'hD3);
    chk("s3_synd", O_synd, 8'h82);

    // Stalls between beats
    step(1, 1, 0, 8'h01);
    step(0, 0, 0, 8'hFF);
    step(0, 1, 1, 8'h3C);
    step(0, 0, 0, 8'h00);
    step(1, 0, 1, 8'hD1);
    chk("s4_synd", O_synd, 8'h00);
    chk("s4_data_v", O_data_v, 1'b1);

    // Single-beat frame
    step(1, 1, 1, 8'hAB);
    chk("s5_len_err", O_len_err, 1'b1);
    chk("s5_data_v", O_data_v, 1'b0);

    // Beat in idle dropped, then abort followed by a full clean frame
    step(1, 0, 0, 8'h77);
    step(1, 1, 0, 8'h5A);
    step(1, 0, 0, 8'h55);
    step(1, 1, 0, 8'h01);
    step(1, 0, 1, 8'hD1);
    chk("s6_synd", O_synd, 8'h00);
    chk("s6_err", O_err, 1'b0);

    // Asynchronous reset mid-frame
    step(1, 1, 0, 8'h01);
    I_data_v = 1'b0; I_data_sof = 1'b0; I_data_eof = 1'b0;
    #3 I_rst = 1'b1;
    #1;
    chk("arst_data", O_data, 8'h00);
    chk("arst_synd", O_synd, 8'h00);
    chk("arst_synd_v", O_synd_v, 1'b0);
    chk("arst_err", O_err, 1'b0);
    chk("arst_len_err", O_len_err, 1'b0);
    in_frame = 1'b0;
    fr.delete();
    exp_data = '0;
    exp_synd = '0;
    @(posedge clk);
    #1 I_rst = 1'b0;
    step(1, 0, 1, 8'hD1);

    // Random frames: clean, single bit error, corrupted beat, or preceded by an aborted start
    for (int f = 0; f < 60; f++) begin
      nd  = $urandom_range(1, 3);
      dat = {32'h0, $urandom} & ((64'h1 << (8 * nd)) - 64'h1);
      bt.delete();
      for (int i = nd - 1; i >= 0; i--) bt.push_back(dat[8*i +: 8]);
      bt.push_back(parity(dat));
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        pos = $urandom_range(0, 8 * (nd + 1) - 1);
        tmp = bt[pos / 8];
        tmp[pos % 8] = ~tmp[pos % 8];
        bt[pos / 8] = tmp;
      end else if (mode == 2) begin
        bt[$urandom_range(0, nd)] = 8'($urandom);
      end else if (mode == 3) begin
        step(1, 1, 0, 8'($urandom));
      end
      nb = bt.size();
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 3) == 0) step(0, 1'($urandom), 1'($urandom), 8'($urandom));
        step(1, i == 0, i == nb - 1, bt[i]);
      end
      if ($urandom_range(0, 4) == 0) step(1, 0, 0, 8'($urandom));
      if ($urandom_range(0, 6) == 0) step(1, 1, 1, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bch_syndrome_check.md
# bch_syndrome_check

Receive-side companion to the BCH encoder. Accepts encoded frames in the encoder's output format: data beats followed by parity beats, MSB-first, with the last parity beat zero-padded at the LSB end. It computes the odd-indexed syndromes S1, S3, …, S(2t−1) on the fly and strips the parity beats from the forwarded stream. It also flags frames that contain errors. Syndromes feed a downstream error-locator (BM/Chien) stage; the stripped payload feeds the correction buffer.

## Interface
- C_DWIDTH, 128: beat width, in bits.
- C_COEF_NUM, 43: correction capability t. Syndromes S(2i+1) are produced for i = 0..t−1.
- C_PRIMPOLY_ORDER, 14: m, the GF(2^m) order.
- C_PRIM_POLY, 15'h4443: primitive polynomial, m+1 bits.
- Derived C_GEN_WIDTH: generator degree, computed by the same cyclotomic-coset count as the encoder.
- Derived C_ECC_BEATS = (C_GEN_WIDTH−1)/C_DWIDTH + 1.
- Derived C_PAD = C_ECC_BEATS*C_DWIDTH − C_GEN_WIDTH.

Ports:
- I_clk  in  1  clock; everything is on the rising edge.
- I_rst  in  1  reset, asynchronous, active-high.
- I_data  in  C_DWIDTH  codeword beat.
- I_data_v  in  1  beat valid. sof/eof are ignored when this is low.
- I_data_sof  in  1  first beat of the codeword.
- I_data_eof  in  1  last parity beat.
- O_data  out  C_DWIDTH  payload beat.
- O_data_v  out  1  payload valid.
- O_data_sof  out  1  first payload beat.
- O_data_eof  out  1  last payload beat.
- O_synd  out  C_COEF_NUM*m  syndromes. S1 is in bits [m−1:0] and S(2i+1) is in bits [(i+1)m−1:im].
- O_synd_v  out  1  one-cycle pulse marking a completed frame.
- O_err  out  1  any syndrome is nonzero. Qualified by O_synd_v.
- O_len_err  out  1  frame had ≤ C_ECC_BEATS beats. Qualified by O_synd_v.

## Operation
- All outputs reset to 0. Reset also clears the accumulators, the delay line and the occupancy count.
- **Syndrome accumulation:** one accumulator per odd j, each m bits wide.
  - Normal beat: S_j ← S_j·α^(jW) ⊕ Σ_k r_k·α^(jk), with bit k = 0 as the latest in time.
  - The first beat (sof) uses S_j = 0 as its prior value.
  - Beat with eof: only bits k ≥ C_PAD are used, with S_j ← S_j·α^(j(W−C_PAD)) ⊕ Σ_{k≥C_PAD} r_k·α^(j(k−C_PAD)). Pad bits are don't-care.
  - All α powers are elaboration-time constants, so each update is an XOR matrix.
- **Parity stripping:**
  - A delay line of C_ECC_BEATS beats plus an occupancy counter, saturating at C_ECC_BEATS.
  - Each valid beat shifts in. The beat shifted out is emitted as payload only when occupancy was already C_ECC_BEATS.
  - The first emitted beat carries O_data_sof.
  - The beat emitted on the eof cycle carries O_data_eof.
  - At eof, the beats remaining in the line are parity and are discarded. Occupancy clears.
- **States:**
  - IDLE → FRAME on a valid sof.
  - FRAME → IDLE on a valid eof.
  - A valid beat in IDLE without sof is dropped.
  - A valid sof in FRAME restarts the frame: accumulators and occupancy clear, and the beat becomes the first beat. No O_synd_v is emitted for the aborted frame.
  - sof and eof on the same beat: single-beat frame. O_synd_v=1 and O_len_err=1 are raised, and no payload is emitted.
- O_len_err=1 whenever the frame had ≤ C_ECC_BEATS beats. In that case no payload is emitted and O_err is still reported.

## Timing
- All outputs are registered.
- Payload latency: the beat accepted at cycle n appears on O_data at n+1 + (C_ECC_BEATS valid beats later).
- Stalls (I_data_v=0) hold everything. O_data_v is 0 during a stall, and O_data holds its last value.
- O_synd, O_err and O_synd_v are valid in the cycle after the eof beat, coincident with O_data_eof.
- O_synd holds its value until the next O_synd_v.
- Throughput: one beat per cycle, no backpressure.
- A new sof may arrive in the cycle directly after an eof.
- Reset is asynchronous mid-frame: the partial frame is lost, and no O_synd_v is emitted for it.

## Structure
- Shared package `bch_pkg`:
  - the F_gen and F_mult GF helpers,
  - the coset-count function for C_GEN_WIDTH,
  - the GETASIZE width function,
  - the C_ECC_BEATS and C_PAD formulas.
- The encoder is to be migrated to import this package.
- One sub-module, `bch_synd_acc`:
  - a single syndrome accumulator for index j,
  - both update matrices as constant functions,
  - instantiated C_COEF_NUM times in a generate loop.
- The delay line, counter and FSM live in the top level.

## Test plan
All scenarios use C_DWIDTH=8, C_COEF_NUM=2, m=4 and C_PRIM_POLY=5'h13 (BCH(15,7), g=0x1D1, C_ECC_BEATS=1, C_PAD=0).

1. **Clean codeword.** Beats 0x01 (sof), 0xD1 (eof) → O_data=0x01 with sof and eof, then O_synd_v=1, O_synd=8'h00, O_err=0.
2. **Single error in parity bit 0.** Beats 0x01, 0xD0 → O_synd=8'h11, O_err=1. Payload 0x01 is unchanged.
3. **Single error in parity bit 1.** Beats 0x01, 0xD3 → O_synd=8'h82.
4. **Stalls between beats.** Scenario 1 with I_data_v low for 3 cycles between beats → identical outputs. O_data_v is high only on the emit cycle.
5. **Length error.** A single beat with sof=eof=1 → O_synd_v=1, O_len_err=1, no O_data_v.
6. **Abort and reset.**
   - A sof in mid-frame, followed by a full clean frame, gives exactly one O_synd_v, with syndromes 0.
   - I_rst asserted mid-frame gives all outputs 0 immediately, with no O_synd_v.
